// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Two-requester round-robin arbiter sharing one SPI master, with
//            lock bursts. Optional XFER watchdog when SPI_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int SETUP_CYC   = 2,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        a_req_valid,
    input  logic [15:0] a_req_data,
    input  logic [1:0]  a_req_mode,
    input  logic        a_req_lock,
    output logic        a_req_ready,
    output logic        a_rsp_valid,
    input  logic        b_req_valid,
    input  logic [15:0] b_req_data,
    input  logic [1:0]  b_req_mode,
    input  logic        b_req_lock,
    output logic        b_req_ready,
    output logic        b_rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  grant,
    output logic        spi_en,
    output logic [1:0]  spi_mode,
    output logic [15:0] spi_sdata,
    input  logic        spi_done,
    input  logic [15:0] spi_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [3:0]  C_SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  C_GAP_LAST   = 4'(GAP_CYC - 1);
    localparam logic [15:0] C_TMO_LAST   = 16'(TIMEOUT_CYC - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        lock_q;
    logic        last_b_q;
    logic [1:0]  grant_q;
    logic        spi_en_q;
    logic [1:0]  spi_mode_q;
    logic [15:0] spi_sdata_q;
    logic [15:0] rsp_data_q;
    logic        a_ready_q;
    logic        b_ready_q;
    logic        a_rsp_q;
    logic        b_rsp_q;

    logic        sel_a_d;
    logic        own_valid_d;
    logic        own_lock_d;
    logic [15:0] own_data_d;
    logic [1:0]  own_mode_d;
    logic        tmo_hit_d;

    // With both pending, A wins only when B was the last owner.
    assign sel_a_d     = a_req_valid & (~b_req_valid | last_b_q);
    assign own_valid_d = grant_q[0] ? a_req_valid : b_req_valid;
    assign own_lock_d  = grant_q[0] ? a_req_lock  : b_req_lock;
    assign own_data_d  = grant_q[0] ? a_req_data  : b_req_data;
    assign own_mode_d  = grant_q[0] ? a_req_mode  : b_req_mode;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        rsp_err_q;

    assign tmo_hit_d = (state_q == S_XFER) && !spi_done && (tmo_q == C_TMO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= tmo_hit_d;
            if ((state_q != S_XFER) || spi_done || tmo_hit_d) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 16'd1;
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^C_TMO_LAST;
    assign tmo_hit_d      = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lock_q      <= 1'b0;
            last_b_q    <= 1'b1;
            grant_q     <= '0;
            spi_en_q    <= 1'b0;
            spi_mode_q  <= '0;
            spi_sdata_q <= '0;
            rsp_data_q  <= '0;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            a_rsp_q     <= 1'b0;
            b_rsp_q     <= 1'b0;
        end else begin
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            a_rsp_q   <= 1'b0;
            b_rsp_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (a_req_valid || b_req_valid) begin
                        if (sel_a_d) begin
                            spi_sdata_q <= a_req_data;
                            spi_mode_q  <= a_req_mode;
                            lock_q      <= a_req_lock;
                            grant_q     <= 2'b01;
                            a_ready_q   <= 1'b1;
                        end else begin
                            spi_sdata_q <= b_req_data;
                            spi_mode_q  <= b_req_mode;
                            lock_q      <= b_req_lock;
                            grant_q     <= 2'b10;
                            b_ready_q   <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == C_SETUP_LAST) begin
                        spi_en_q <= 1'b1;
                        state_q  <= S_XFER;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_XFER: begin
                    if (spi_done) begin
                        rsp_data_q <= spi_rdata;
                        a_rsp_q    <= grant_q[0];
                        b_rsp_q    <= grant_q[1];
                        if (lock_q && own_valid_d) begin
                            // Chain: chip select stays asserted, next word loaded.
                            spi_sdata_q <= own_data_d;
                            spi_mode_q  <= own_mode_d;
                            lock_q      <= own_lock_d;
                            a_ready_q   <= grant_q[0];
                            b_ready_q   <= grant_q[1];
                        end else begin
                            spi_en_q <= 1'b0;
                            last_b_q <= grant_q[1];
                            grant_q  <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_GAP;
                        end
                    end else if (tmo_hit_d) begin
                        rsp_data_q <= '0;
                        a_rsp_q    <= grant_q[0];
                        b_rsp_q    <= grant_q[1];
                        lock_q     <= 1'b0;
                        spi_en_q   <= 1'b0;
                        last_b_q   <= grant_q[1];
                        grant_q    <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == C_GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_req_ready = a_ready_q;
    assign b_req_ready = b_ready_q;
    assign a_rsp_valid = a_rsp_q;
    assign b_rsp_valid = b_rsp_q;
    assign rsp_data    = rsp_data_q;
    assign grant       = grant_q;
    assign spi_en      = spi_en_q;
    assign spi_mode    = spi_mode_q;
    assign spi_sdata   = spi_sdata_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Directed self-checking bench for spi_arbiter (SETUP=2, GAP=4, TIMEOUT=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    localparam int SETUP_CYC   = 2;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 50;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic [15:0] a_req_data  = '0,   b_req_data  = '0;
    logic [1:0]  a_req_mode  = '0,   b_req_mode  = '0;
    logic        a_req_lock  = 1'b0, b_req_lock  = 1'b0;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [1:0]  grant;
    logic        spi_en;
    logic [1:0]  spi_mode;
    logic [15:0] spi_sdata;
    logic        spi_done  = 1'b0;
    logic [15:0] spi_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    spi_arbiter #(
        .SETUP_CYC   (SETUP_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .a_req_valid (a_req_valid),
        .a_req_data  (a_req_data),
        .a_req_mode  (a_req_mode),
        .a_req_lock  (a_req_lock),
        .a_req_ready (a_req_ready),
        .a_rsp_valid (a_rsp_valid),
        .b_req_valid (b_req_valid),
        .b_req_data  (b_req_data),
        .b_req_mode  (b_req_mode),
        .b_req_lock  (b_req_lock),
        .b_req_ready (b_req_ready),
        .b_rsp_valid (b_rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .grant       (grant),
        .spi_en      (spi_en),
        .spi_mode    (spi_mode),
        .spi_sdata   (spi_sdata),
        .spi_done    (spi_done),
        .spi_rdata   (spi_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Master completes a word: done is sampled at the next edge, returns in the cycle after.
    task automatic done_pulse(input logic [15:0] rd);
        spi_done  = 1'b1;
        spi_rdata = rd;
        tick();
        spi_done  = 1'b0;
    endtask

    task automatic gap_wait();
        repeat (GAP_CYC) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_en", 32'(spi_en), 0);
        check_eq("rst_sdata", 32'(spi_sdata), 0);
        check_eq("rst_mode", 32'(spi_mode), 0);
        check_eq("rst_ready", 32'({a_req_ready, b_req_ready}), 0);
        check_eq("rst_rsp", 32'({a_rsp_valid, b_rsp_valid}), 0);
        check_eq("rst_rdata", 32'(rsp_data), 0);
        sys_rst_n = 1'b1;
        tick();

        // Simultaneous A and B from reset: A first, B after the gap
        a_req_valid = 1'b1; a_req_data = 16'h1111; a_req_mode = 2'd1; a_req_lock = 1'b0;
        b_req_valid = 1'b1; b_req_data = 16'h2222; b_req_mode = 2'd2; b_req_lock = 1'b0;
        tick();
        check_eq("sim_a_ready", 32'(a_req_ready), 1);
        check_eq("sim_b_ready0", 32'(b_req_ready), 0);
        check_eq("sim_grant_a", 32'(grant), 32'h1);
        check_eq("sim_sdata_a", 32'(spi_sdata), 32'h1111);
        check_eq("sim_mode_a", 32'(spi_mode), 1);
        a_req_valid = 1'b0;
        tick();
        check_eq("sim_setup_en0", 32'(spi_en), 0);
        tick();
        check_eq("sim_setup_en1", 32'(spi_en), 1);
        done_pulse(16'hA1A1);
        check_eq("sim_a_rsp", 32'(a_rsp_valid), 1);
        check_eq("sim_a_rdata", 32'(rsp_data), 32'hA1A1);
        check_eq("sim_grant_none", 32'(grant), 0);
        check_eq("sim_en_fall", 32'(spi_en), 0);
        gap_wait();
        check_eq("sim_gap_grant", 32'(grant), 0);
        check_eq("sim_gap_b_ready", 32'(b_req_ready), 0);
        tick();
        check_eq("sim_b_ready", 32'(b_req_ready), 1);
        check_eq("sim_grant_b", 32'(grant), 32'h2);
        check_eq("sim_sdata_b", 32'(spi_sdata), 32'h2222);
        b_req_valid = 1'b0;
        tick(); tick();
        check_eq("sim_b_en", 32'(spi_en), 1);
        done_pulse(16'hB2B2);
        check_eq("sim_b_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'h1);
        check_eq("sim_b_rdata", 32'(rsp_data), 32'hB2B2);
        gap_wait();

        // Lock burst: A sends three words, B waits the whole burst
        a_req_valid = 1'b1; a_req_data = 16'h0101; a_req_mode = 2'd0; a_req_lock = 1'b1;
        b_req_valid = 1'b1; b_req_data = 16'h0B0B; b_req_lock = 1'b0;
        tick();
        check_eq("lk_ready1", 32'(a_req_ready), 1);
        check_eq("lk_grant", 32'(grant), 32'h1);
        a_req_data = 16'h0202; a_req_lock = 1'b1;
        tick(); tick();
        check_eq("lk_en", 32'(spi_en), 1);
        repeat (3) tick();
        check_eq("lk_xfer_no_ready", 32'(a_req_ready), 0);
        done_pulse(16'hD001);
        check_eq("lk_rsp1", 32'(a_rsp_valid), 1);
        check_eq("lk_rdata1", 32'(rsp_data), 32'hD001);
        check_eq("lk_ready2", 32'(a_req_ready), 1);
        check_eq("lk_sdata2", 32'(spi_sdata), 32'h0202);
        check_eq("lk_en_held1", 32'(spi_en), 1);
        check_eq("lk_grant_held", 32'(grant), 32'h1);
        a_req_data = 16'h0303; a_req_lock = 1'b0;
        repeat (2) tick();
        done_pulse(16'hD002);
        check_eq("lk_ready3", 32'(a_req_ready), 1);
        check_eq("lk_sdata3", 32'(spi_sdata), 32'h0303);
        check_eq("lk_en_held2", 32'(spi_en), 1);
        check_eq("lk_rdata2", 32'(rsp_data), 32'hD002);
        a_req_valid = 1'b0;
        tick();
        check_eq("lk_rsp_pulse", 32'(a_rsp_valid), 0);
        done_pulse(16'hD003);
        check_eq("lk_rsp3", 32'(a_rsp_valid), 1);
        check_eq("lk_rdata3", 32'(rsp_data), 32'hD003);
        check_eq("lk_en_end", 32'(spi_en), 0);
        check_eq("lk_grant_end", 32'(grant), 0);
        check_eq("lk_no_ready", 32'({a_req_ready, b_req_ready}), 0);
        gap_wait();
        check_eq("lk_b_wait", 32'(b_req_ready), 0);
        tick();
        check_eq("lk_b_ready", 32'(b_req_ready), 1);
        check_eq("lk_b_grant", 32'(grant), 32'h2);
        check_eq("lk_b_sdata", 32'(spi_sdata), 32'h0B0B);
        b_req_valid = 1'b0;
        tick(); tick();
        done_pulse(16'hBEEF);
        check_eq("lk_b_rsp", 32'(b_rsp_valid), 1);
        gap_wait();

        // Single word: mode 3, master answers after 20 cycles
        a_req_valid = 1'b1; a_req_data = 16'hAAAB; a_req_mode = 2'd3; a_req_lock = 1'b0;
        tick();
        check_eq("sw_ready", 32'(a_req_ready), 1);
        check_eq("sw_sdata", 32'(spi_sdata), 32'hAAAB);
        check_eq("sw_mode", 32'(spi_mode), 3);
        a_req_valid = 1'b0;
        tick();
        check_eq("sw_en_n2", 32'(spi_en), 0);
        tick();
        check_eq("sw_en_n3", 32'(spi_en), 1);
        repeat (19) tick();
        check_eq("sw_en_hold", 32'(spi_en), 1);
        done_pulse(16'h1234);
        check_eq("sw_rsp", 32'(a_rsp_valid), 1);
        check_eq("sw_rdata", 32'(rsp_data), 32'h1234);
        check_eq("sw_err", 32'(rsp_err), 0);
        check_eq("sw_en_fall", 32'(spi_en), 0);
        // Lock without next word: request waits out the gap
        a_req_valid = 1'b1; a_req_data = 16'h5A5A; a_req_mode = 2'd0; a_req_lock = 1'b1;
        for (int i = 0; i < GAP_CYC; i++) begin
            tick();
            check_eq("sw_gap_en", 32'(spi_en), 0);
            check_eq("sw_gap_ready", 32'(a_req_ready), 0);
        end
        tick();
        check_eq("sw_gap_min_ready", 32'(a_req_ready), 1);
        a_req_valid = 1'b0;
        tick(); tick();
        check_eq("ln_en", 32'(spi_en), 1);
        done_pulse(16'hC0C0);
        check_eq("ln_rsp", 32'(a_rsp_valid), 1);
        check_eq("ln_en_fall", 32'(spi_en), 0);
        check_eq("ln_grant", 32'(grant), 0);
        // Stray spi_done in GAP must be ignored
        a_req_valid = 1'b1; a_req_data = 16'h6666; a_req_lock = 1'b0;
        spi_done = 1'b1; spi_rdata = 16'hFFFF;
        tick();
        spi_done = 1'b0;
        check_eq("gap_done_ignored", 32'(a_rsp_valid), 0);
        check_eq("gap_done_rdata", 32'(rsp_data), 32'hC0C0);
        repeat (3) tick();
        check_eq("ln_rearb_wait", 32'(a_req_ready), 0);
        tick();
        check_eq("ln_rearb_ready", 32'(a_req_ready), 1);
        check_eq("ln_rearb_sdata", 32'(spi_sdata), 32'h6666);
        a_req_valid = 1'b0;
        tick(); tick();
        done_pulse(16'h7777);
        check_eq("ln_rearb_rdata", 32'(rsp_data), 32'h7777);
        gap_wait();

`ifdef SPI_ARB_TIMEOUT_EN
        // Timeout: master never completes
        a_req_valid = 1'b1; a_req_data = 16'h1357; a_req_lock = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick(); tick();
        check_eq("to_en", 32'(spi_en), 1);
        repeat (TIMEOUT_CYC - 1) tick();
        check_eq("to_en_last", 32'(spi_en), 1);
        check_eq("to_no_rsp", 32'(a_rsp_valid), 0);
        tick();
        check_eq("to_rsp", 32'(a_rsp_valid), 1);
        check_eq("to_err", 32'(rsp_err), 1);
        check_eq("to_rdata", 32'(rsp_data), 0);
        check_eq("to_en_fall", 32'(spi_en), 0);
        tick();
        check_eq("to_err_pulse", 32'(rsp_err), 0);
        a_req_valid = 1'b1; a_req_data = 16'h2468; a_req_lock = 1'b0;
        repeat (4) tick();
        check_eq("to_next_ready", 32'(a_req_ready), 1);
        a_req_valid = 1'b0;
        tick(); tick();
        done_pulse(16'h9999);
        check_eq("to_next_rdata", 32'(rsp_data), 32'h9999);
        check_eq("to_next_err", 32'(rsp_err), 0);
        gap_wait();
`endif

        // Reset mid-XFER
        a_req_valid = 1'b1; a_req_data = 16'h4321; a_req_lock = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("rx_en_before", 32'(spi_en), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_eq("rx_en_async", 32'(spi_en), 0);
        check_eq("rx_grant_async", 32'(grant), 0);
        check_eq("rx_sdata_async", 32'(spi_sdata), 0);
        check_eq("rx_rsp_async", 32'({a_rsp_valid, b_rsp_valid}), 0);
        spi_done = 1'b1; spi_rdata = 16'hDEAD;
        tick(); tick();
        spi_done = 1'b0;
        a_req_valid = 1'b1; a_req_data = 16'h0A0A; a_req_lock = 1'b0;
        b_req_valid = 1'b1; b_req_data = 16'h0B0C; b_req_lock = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        check_eq("rx_a_first", 32'({b_req_ready, a_req_ready}), 32'h1);
        check_eq("rx_grant_a", 32'(grant), 32'h1);
        check_eq("rx_no_rsp", 32'({a_rsp_valid, b_rsp_valid}), 0);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        tick(); tick();
        done_pulse(16'h1A1A);
        check_eq("rx_rsp", 32'(a_rsp_valid), 1);
        check_eq("rx_rdata", 32'(rsp_data), 32'h1A1A);
        gap_wait();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Two-requester round-robin arbiter that shares one `spi_master` instance (16-bit word, level `spi_en`, one-cycle `spi_done` per word). It sits between the SPI master and two configuration clients, such as a register initialiser and a runtime poller. For each granted word it drives `spi_mode`, `spi_sdata` and `spi_en`, captures `spi_rdata` on `spi_done`, and returns the read data to the owning requester. A lock flag lets a requester chain several words under one continuous `spi_en` assertion (chip select held).

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles `spi_mode`/`spi_sdata` are held stable before `spi_en` rises (1..15).
- `GAP_CYC`, default 4: minimum cycles `spi_en` stays low between transactions (1..15).
- `TIMEOUT_CYC`, default 1000: watchdog limit in XFER, 16 bits. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `sys_clk` in 1: single clock; all logic on the rising edge.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `a_req_valid`, `b_req_valid` in 1: word request pending.
- `a_req_data`, `b_req_data` in 16: word to transmit.
- `a_req_mode`, `b_req_mode` in 2: SPI mode (CPOL/CPHA) for the word.
- `a_req_lock`, `b_req_lock` in 1: continue the burst after this word.
- `a_req_ready`, `b_req_ready` out 1: one-cycle pulse; the word was latched.
- `a_rsp_valid`, `b_rsp_valid` out 1: one-cycle pulse; `rsp_data`/`rsp_err` are valid.
- `rsp_data` out 16: captured `spi_rdata`.
- `rsp_err` out 1: word aborted by timeout.
- `grant` out 2: one-hot owner (01 = A, 10 = B, 00 = none).
- `spi_en` out 1: master enable.
- `spi_mode` out 2: master mode.
- `spi_sdata` out 16: master transmit word.
- `spi_done` in 1: master word complete (1 cycle).
- `spi_rdata` in 16: master receive word, valid with `spi_done`.

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer = "B served last", so A wins first.
- States: IDLE, SETUP, XFER, GAP.
- IDLE:
  - If any `*_req_valid` is set, select the requester. With both valid, select the one not served last.
  - Latch its data, mode and lock into `spi_sdata`, `spi_mode` and an internal lock bit.
  - Pulse its `req_ready`, set `grant`, go to SETUP.
- SETUP: count `SETUP_CYC` cycles, then set `spi_en`=1 and go to XFER.
- XFER: hold `spi_en`=1 and wait for `spi_done`. On `spi_done`:
  - Register `spi_rdata` into `rsp_data` and pulse the owner's `rsp_valid`.
  - **Chain:** if the lock bit is 1 and the owner's `req_valid` is 1 in the same cycle, latch the new data, mode and lock, pulse `req_ready`, and stay in XFER with `spi_en` held at 1.
  - **End burst:** otherwise set `spi_en`=0, update the round-robin pointer to the owner, clear `grant`, and go to GAP.
  - A mode change on a chained word is latched but ignored by the master until the next burst. Requesters must not change mode inside a lock burst.
- GAP: count `GAP_CYC` cycles with `spi_en`=0, then return to IDLE. Requests arriving during GAP wait.
- The non-owner is never granted mid-burst. Fairness is per burst, not per word.
- A `req_valid` deasserted before `req_ready` is simply not served; no error is raised.
- Asserting `sys_rst_n` low mid-transfer immediately clears `spi_en`, `grant` and all pulses. No response is issued for the in-flight word.

## Timing
- `req_valid` sampled at edge N in IDLE:
  - `req_ready` high in cycle N+1.
  - `spi_sdata`/`spi_mode` valid from N+1.
  - `spi_en` rises at N+1+`SETUP_CYC`.
- `spi_done` at edge M:
  - `rsp_valid` and `rsp_data` appear at M+1, for exactly one cycle.
  - On a chain, the new `spi_sdata` is valid at M+1. The master loads its next word no earlier than M+1.
  - On a burst end, `spi_en` falls at M+1, and the earliest next grant is at M+1+`GAP_CYC`+1.
- `spi_done` outside XFER is ignored.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in XFER and clears on `spi_done`/chain.
  - When it reaches `TIMEOUT_CYC`: pulse the owner's `rsp_valid` with `rsp_err`=1 and `rsp_data`=16'h0000, drop `spi_en`, discard the lock, go to GAP.
  - `rsp_err` is 0 on normal completion.
- Macro undefined: no counter is built, `rsp_err` is tied 0, and XFER waits indefinitely.

## Test plan
- **Single word:** A valid, data 16'hAAAB, mode 3; master returns 16'h1234 after 20 cycles.
  - `a_req_ready` fires at N+1 and `spi_en` rises at N+3.
  - `a_rsp_valid` fires with `rsp_data`=16'h1234, and `spi_en` is low for 4 cycles after.
- **Simultaneous A and B from reset:** A is served first, then B after the gap. `grant` sequence is 01, 00, 10.
- **Lock burst:** A sends 3 words, lock=1,1,0.
  - `spi_en` stays high across all three `spi_done` pulses.
  - B, valid throughout, is granted only after the gap.
- **Lock without next word:** A lock=1 but `a_req_valid`=0 at `spi_done`. `spi_en` falls at M+1 and A must rearbitrate.
- **Timeout (`SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=50):** the master never asserts `spi_done`.
  - `rsp_err`=1 and `rsp_data`=0 at XFER cycle 50, then `spi_en` falls.
  - The next request is served normally.
- **Reset mid-XFER:** `spi_en`, `grant`, `spi_sdata` read 0 asynchronously, with no `rsp_valid`. After release, A wins first again.
